dmem_arbiter: RTL and testbench

//  Shares the single-port data memory between the pipeline MEM stage (CPU port) and one external burst master (loader/DMA port).
//  CPU accesses complete with zero latency when the memory is free. External bursts own the memory for consecutive cycles.
//  The CPU port stalls while a burst owns the memory. Sits between the MEM stage and data_memory.

---
 rtl/dmem_arbiter_pkg.sv | 9 +
 rtl/dmem_arbiter_burst_ctr.sv | 44 ++++
 rtl/dmem_arbiter.sv | 154 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding and beat address stride.
package dmem_arbiter_pkg;
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXT  = 1'b1
  } state_t;

  localparam int WORD_BYTES = 4;
endpackage

// File: rtl/dmem_arbiter_burst_ctr.sv
// Burst bookkeeping: latched start address/length and beat index; beat 0 is issued by the top
// in the grant cycle, so a load leaves the index pointing at beat 1.
module dmem_arbiter_burst_ctr
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_advance,
  input  logic              i_clear,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LEN_W-1:0]  i_len,
  output logic [ADDR_W-1:0] o_beat_addr,
  output logic [LEN_W-1:0]  o_idx,
  output logic              o_last
);
  logic [ADDR_W-1:0] r_start;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_idx;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_start <= '0;
      r_len   <= '0;
      r_idx   <= '0;
    end else if (i_clear) begin
      r_idx <= '0;
    end else if (i_load) begin
      r_start <= i_addr;
      r_len   <= i_len;
      r_idx   <= LEN_W'(1);
    end else if (i_advance) begin
      r_idx <= r_idx + LEN_W'(1);
    end
  end

  // Address arithmetic is ADDR_W wide, so the beat address wraps naturally.
  assign o_beat_addr = r_start + ADDR_W'(WORD_BYTES) * ADDR_W'(r_idx);
  assign o_idx       = r_idx;
  assign o_last      = (r_idx == r_len);
endmodule

// File: rtl/dmem_arbiter.sv
// Shares single-port data memory between the MEM stage and an external burst master; CPU has
// priority in IDLE, bursts are never preempted. Optional anti-starvation grant: DMEM_ARB_STARVE_EN.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LEN_W    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [LEN_W-1:0]  ext_len,
  output logic              ext_gnt,
  output logic              ext_beat,
  output logic [LEN_W-1:0]  ext_beat_idx,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);
  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_we_q;
  logic              w_forced;
  logic              w_gnt;
  logic              w_load;
  logic              w_adv;
  logic              w_clr;
  logic [ADDR_W-1:0] w_beat_addr;
  logic [LEN_W-1:0]  w_idx;
  logic              w_last;

  if (MAX_WAIT < 1) begin : g_max_wait_chk
    $error("MAX_WAIT must be at least 1");
  end

`ifdef DMEM_ARB_STARVE_EN
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  logic [WAIT_W-1:0] r_wait;

  // Grant clears it, so the counter never passes MAX_WAIT.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wait <= '0;
    end else if (w_gnt) begin
      r_wait <= '0;
    end else if (r_state == ST_IDLE && ext_req && cpu_req) begin
      r_wait <= r_wait + WAIT_W'(1);
    end
  end

  assign w_forced = (r_wait >= WAIT_W'(MAX_WAIT));
`else
  assign w_forced = 1'b0;
`endif

  assign w_gnt = rst && (r_state == ST_IDLE) && ext_req && (!cpu_req || w_forced);

  dmem_arbiter_burst_ctr #(
    .ADDR_W(ADDR_W),
    .LEN_W (LEN_W)
  ) u_burst_ctr (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_advance  (w_adv),
    .i_clear    (w_clr),
    .i_addr     (ext_addr),
    .i_len      (ext_len),
    .o_beat_addr(w_beat_addr),
    .o_idx      (w_idx),
    .o_last     (w_last)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_we_q  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) r_we_q <= ext_we;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_load       = 1'b0;
    w_adv        = 1'b0;
    w_clr        = 1'b0;
    ext_gnt      = 1'b0;
    ext_beat     = 1'b0;
    ext_beat_idx = '0;
    ext_done     = 1'b0;
    cpu_stall    = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wd       = '0;
    if (!rst) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gnt) begin
            ext_gnt   = 1'b1;
            ext_beat  = 1'b1;
            mem_we    = ext_we;
            mem_addr  = ext_addr;
            mem_wd    = ext_wdata;
            cpu_stall = cpu_req;
            w_load    = 1'b1;
            if (ext_len == '0) ext_done = 1'b1;
            else               w_state_nxt = ST_EXT;
          end else if (cpu_req) begin
            mem_we   = cpu_we;
            mem_addr = cpu_addr;
            mem_wd   = cpu_wdata;
          end
        end
        ST_EXT: begin
          ext_beat     = 1'b1;
          ext_beat_idx = w_idx;
          mem_we       = r_we_q;
          mem_addr     = w_beat_addr;
          mem_wd       = ext_wdata;
          cpu_stall    = cpu_req;
          if (w_last) begin
            ext_done    = 1'b1;
            w_clr       = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_adv = 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign cpu_rdata = mem_rd;
  assign ext_rdata = mem_rd;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic, checked every cycle against a
// transaction-level model with its own reference memory.
module tb_dmem_arbiter;
  localparam int MW = 8;
`ifdef DMEM_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_stall;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        ext_req, ext_we, ext_gnt, ext_beat, ext_done;
  logic [31:0] ext_addr, ext_wdata, ext_rdata;
  logic [3:0]  ext_len, ext_beat_idx;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic [31:0] dbase;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_len(ext_len),
    .ext_gnt(ext_gnt), .ext_beat(ext_beat), .ext_beat_idx(ext_beat_idx),
    .ext_wdata(ext_wdata), .ext_rdata(ext_rdata), .ext_done(ext_done),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // Burst data for beat i is dbase+i, driven from the index the DUT reports.
  assign ext_wdata = dbase + {28'd0, ext_beat_idx};

  logic [31:0] emu [0:1023];
  logic [31:0] ref_mem [0:1023];
  assign mem_rd = emu[mem_addr[11:2]];
  always @(posedge clk) if (mem_we) emu[mem_addr[11:2]] <= mem_wd;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Transaction-level model: one burst record plus a refusal count.
  bit          m_ext  = 1'b0;
  bit          m_we   = 1'b0;
  logic [31:0] m_base = '0;
  int          m_len  = 0;
  int          m_idx  = 0;
  int          m_wait = 0;

  initial begin : model
    logic [31:0] e_addr, e_wd, rv;
    bit e_gnt, e_beat, e_done, e_stall, e_we, cpu_acc, forced;
    int e_idx;
    forever begin
      @(negedge clk);
      e_gnt = 0; e_beat = 0; e_done = 0; e_stall = 0; e_we = 0; cpu_acc = 0;
      e_addr = '0; e_wd = '0; e_idx = 0;
      if (!rst) begin
        m_ext = 0;
        m_wait = 0;
      end else if (m_ext) begin
        e_beat = 1; e_idx = m_idx; e_we = m_we; e_stall = cpu_req;
        e_addr = m_base + 32'(4 * m_idx);
        e_wd = dbase + 32'(m_idx);
        if (m_idx == m_len) begin
          e_done = 1;
          m_ext = 0;
        end else begin
          m_idx++;
        end
      end else begin
        forced = STARVE && (m_wait >= MW);
        if (ext_req && (!cpu_req || forced)) begin
          e_gnt = 1; e_beat = 1; e_addr = ext_addr; e_we = ext_we; e_wd = dbase;
          e_stall = cpu_req; e_done = (ext_len == 4'd0);
          m_ext = (ext_len != 4'd0); m_base = ext_addr; m_len = int'(ext_len);
          m_idx = 1; m_we = ext_we; m_wait = 0;
        end else if (cpu_req) begin
          cpu_acc = 1; e_addr = cpu_addr; e_we = cpu_we; e_wd = cpu_wdata;
          if (STARVE && ext_req) m_wait++;
        end
      end
      chk("m_gnt", 32'(ext_gnt), 32'(e_gnt));
      chk("m_beat", 32'(ext_beat), 32'(e_beat));
      chk("m_done", 32'(ext_done), 32'(e_done));
      chk("m_stall", 32'(cpu_stall), 32'(e_stall));
      chk("m_we", 32'(mem_we), 32'(e_we));
      if (!rst) begin
        chk("m_rst_addr", mem_addr, 32'd0);
        chk("m_rst_wd", mem_wd, 32'd0);
      end
      if (e_beat) chk("m_idx", 32'(ext_beat_idx), 32'(e_idx));
      if (e_beat || cpu_acc) begin
        chk("m_addr", mem_addr, e_addr);
        chk("m_wd", mem_wd, e_wd);
        rv = ref_mem[e_addr[11:2]];
        if (cpu_acc && !e_we) chk("m_cpu_rdata", cpu_rdata, rv);
        if (e_beat && !e_we) chk("m_ext_rdata", ext_rdata, rv);
        if (e_we) ref_mem[e_addr[11:2]] = e_wd;
      end
    end
  end

  initial begin : stim
    int gc;
    bit pend, gnt_seen, stall_seen;
    for (int i = 0; i < 1024; i++) begin
      emu[i] = '0;
      ref_mem[i] = '0;
    end
    rst = 0; dbase = 0;
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h40; cpu_wdata = 32'h1234;
    ext_req = 1; ext_we = 1; ext_addr = 32'h80; ext_len = 4'd2;
    smp();
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_gnt", 32'(ext_gnt), 32'd0);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    step(); cpu_req = 0; ext_req = 0;
    step(); rst = 1;

    // CPU store then load
    step(); cpu_req = 1; cpu_we = 1; cpu_addr = 32'h40; cpu_wdata = 32'hDEADBEEF;
    smp(); chk("t1_st_stall", 32'(cpu_stall), 32'd0); chk("t1_st_we", 32'(mem_we), 32'd1);
    step(); cpu_we = 0;
    smp(); chk("t1_ld_stall", 32'(cpu_stall), 32'd0); chk("t1_ld_data", cpu_rdata, 32'hDEADBEEF);

    // 4-beat write burst, then CPU reads back beat 2
    step(); cpu_req = 0; ext_req = 1; ext_we = 1; ext_addr = 32'h100; ext_len = 4'd3; dbase = 32'd1;
    smp(); chk("t2_gnt", 32'(ext_gnt), 32'd1); chk("t2_addr0", mem_addr, 32'h100);
    for (int k = 1; k <= 3; k++) begin
      step(); ext_req = 0;
      smp();
      chk("t2_addr", mem_addr, 32'h100 + 32'(4 * k));
      chk("t2_gnt_low", 32'(ext_gnt), 32'd0);
      chk("t2_done", 32'(ext_done), 32'(k == 3));
    end
    step(); cpu_req = 1; cpu_we = 0; cpu_addr = 32'h108;
    smp(); chk("t2_ld", cpu_rdata, 32'd3); chk("t2_ld_stall", 32'(cpu_stall), 32'd0);

    // CPU load collides with a read burst
    step(); cpu_req = 0; ext_req = 1; ext_we = 0; ext_addr = 32'h100; ext_len = 4'd3;
    smp(); chk("t3_gnt", 32'(ext_gnt), 32'd1); chk("t3_rd0", ext_rdata, 32'd1);
    step(); ext_req = 0; cpu_req = 1; cpu_addr = 32'h40;
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) step();
      smp();
      chk("t3_stall", 32'(cpu_stall), 32'd1);
      chk("t3_rd", ext_rdata, 32'(k + 1));
      chk("t3_done", 32'(ext_done), 32'(k == 3));
    end
    step();
    smp(); chk("t3_served", 32'(cpu_stall), 32'd0); chk("t3_data", cpu_rdata, 32'hDEADBEEF);

    // Address wrap
    step(); cpu_req = 0; ext_req = 1; ext_we = 1; ext_addr = 32'hFFFFFFFC; ext_len = 4'd1; dbase = 32'h50;
    smp(); chk("t5_a0", mem_addr, 32'hFFFFFFFC);
    step(); ext_req = 0;
    smp(); chk("t5_a1", mem_addr, 32'h0); chk("t5_done", 32'(ext_done), 32'd1);

    // Reset mid-burst
    step(); ext_req = 1; ext_we = 1; ext_addr = 32'h200; ext_len = 4'd7; dbase = 32'hA0;
    smp(); chk("t6_gnt", 32'(ext_gnt), 32'd1);
    step(); ext_req = 0;
    smp(); chk("t6_idx1", 32'(ext_beat_idx), 32'd1);
    step(); rst = 0;
    smp(); chk("t6_we", 32'(mem_we), 32'd0); chk("t6_done", 32'(ext_done), 32'd0);
    step(); rst = 1;
    smp(); chk("t6_idle", 32'(ext_beat), 32'd0);
    step(); ext_req = 1; ext_we = 0; ext_addr = 32'h300; ext_len = 4'd0;
    smp(); chk("t6_regnt", 32'(ext_gnt), 32'd1); chk("t6_redone", 32'(ext_done), 32'd1);
    step(); ext_req = 0;
    smp(); chk("t6_after", 32'(ext_beat), 32'd0);

    // Starvation: CPU requests every cycle for 20 cycles
    step(); cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
    ext_req = 1; ext_we = 0; ext_addr = 32'h400; ext_len = 4'd2;
    gc = -1;
    for (int c = 0; c < 20; c++) begin
      smp();
      if (ext_gnt && gc < 0) begin
        gc = c;
        chk("t4_stall", 32'(cpu_stall), 32'd1);
      end
      step();
      if (gc >= 0) ext_req = 0;
    end
    chk("t4_gnt_cycle", 32'(gc), STARVE ? 32'd8 : 32'hFFFFFFFF);
    cpu_req = 0;
    smp();
    if (!STARVE) chk("t4_late_gnt", 32'(ext_gnt), 32'd1);
    step(); ext_req = 0;
    repeat (3) step();

    // Random traffic
    pend = 0; gnt_seen = 0; stall_seen = 0;
    for (int i = 0; i < 2000; i++) begin
      if (i > 0) step();
      rst = ($urandom_range(0, 149) != 0);
      if (!(cpu_req && stall_seen)) begin
        cpu_req = $urandom_range(0, 1) == 1;
        cpu_we = $urandom_range(0, 1) == 1;
        cpu_addr = $urandom;
        cpu_wdata = $urandom;
      end
      if (pend && gnt_seen) begin
        pend = 0;
        ext_req = 0;
      end
      if (!pend && $urandom_range(0, 3) == 0) begin
        pend = 1; ext_req = 1;
        ext_we = $urandom_range(0, 1) == 1;
        ext_addr = $urandom & 32'hFFFFFFFC;
        ext_len = 4'($urandom_range(0, 15));
        dbase = $urandom;
      end
      smp();
      gnt_seen = ext_gnt;
      stall_seen = cpu_stall;
    end

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
